// File: rtl/jk_mode_counter.sv
// ============================================================================
// Module     : jk_mode_counter
// Description: WIDTH-bit state counter with hold/up/down/toggle modes, a
//              clock-enable divider, load, and wrap/zero event flags.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_mode_counter #(
  parameter int WIDTH  = 4,
  parameter int MAXVAL = 15,
  parameter int DIV    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             Z1,
  output logic             Z2,
  output logic             tick
);

  localparam int               c_cnt_w    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(DIV - 1);
  localparam logic [WIDTH-1:0] c_max      = WIDTH'(MAXVAL);

  localparam logic [1:0] c_mode_hold   = 2'b00;
  localparam logic [1:0] c_mode_up     = 2'b01;
  localparam logic [1:0] c_mode_down   = 2'b10;
  localparam logic [1:0] c_mode_toggle = 2'b11;

  logic [c_cnt_w-1:0] r_div_cnt;
  logic [WIDTH-1:0]   r_q;
  logic               r_z1;

  logic               w_tick;
  logic [WIDTH-1:0]   w_load_val;
  logic [WIDTH-1:0]   w_toggle;
  logic [WIDTH-1:0]   w_toggle_val;

  assign w_tick       = en && (r_div_cnt == c_div_last);
  // Both load and toggle can produce values above MAXVAL; clamp them here.
  assign w_load_val   = (d > c_max) ? c_max : d;
  assign w_toggle     = ~r_q;
  assign w_toggle_val = (w_toggle > c_max) ? c_max : w_toggle;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q       <= '0;
      r_div_cnt <= '0;
      r_z1      <= 1'b0;
    end else if (load) begin
      r_q       <= w_load_val;
      r_div_cnt <= '0;
      r_z1      <= 1'b0;
    end else begin
      r_z1 <= 1'b0;
      if (en) begin
        r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + c_cnt_w'(1);
      end
      if (w_tick) begin
        case (mode)
          c_mode_hold: r_q <= r_q;
          c_mode_up: begin
            if (r_q == c_max) begin
              r_q  <= '0;
              r_z1 <= 1'b1;
            end else begin
              r_q <= r_q + WIDTH'(1);
            end
          end
          c_mode_down: begin
            if (r_q == '0) begin
              r_q  <= c_max;
              r_z1 <= 1'b1;
            end else begin
              r_q <= r_q - WIDTH'(1);
            end
          end
          c_mode_toggle: r_q <= w_toggle_val;
          default:       r_q <= r_q;
        endcase
      end
    end
  end

  assign Q    = r_q;
  assign Qb   = ~r_q;
  assign Z1   = r_z1;
  assign Z2   = (r_q == '0);
  assign tick = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_jk_mode_counter.sv
// ============================================================================
// Module     : tb_jk_mode_counter
// Description: Directed bench over three counter configurations.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_mode_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // a: MAXVAL 15, DIV 1   b: MAXVAL 15, DIV 4   c: MAXVAL 9, DIV 1
  logic       en_a, en_b, en_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic       load_a, load_b, load_c;
  logic [3:0] d_a, d_b, d_c;
  logic [3:0] q_a, q_b, q_c, qb_a, qb_b, qb_c;
  logic       z1_a, z1_b, z1_c, z2_a, z2_b, z2_c, tick_a, tick_b, tick_c;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] b_q;
  int         b_div;

  jk_mode_counter #(.WIDTH(4), .MAXVAL(15), .DIV(1)) u_a (
    .clk(clk), .reset(reset), .en(en_a), .mode(mode_a), .load(load_a), .d(d_a),
    .Q(q_a), .Qb(qb_a), .Z1(z1_a), .Z2(z2_a), .tick(tick_a));

  jk_mode_counter #(.WIDTH(4), .MAXVAL(15), .DIV(4)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .mode(mode_b), .load(load_b), .d(d_b),
    .Q(q_b), .Qb(qb_b), .Z1(z1_b), .Z2(z2_b), .tick(tick_b));

  jk_mode_counter #(.WIDTH(4), .MAXVAL(9), .DIV(1)) u_c (
    .clk(clk), .reset(reset), .en(en_c), .mode(mode_c), .load(load_c), .d(d_c),
    .Q(q_c), .Qb(qb_c), .Z1(z1_c), .Z2(z2_c), .tick(tick_c));

  task automatic edge_step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    en_a = 0; en_b = 0; en_c = 0;
    mode_a = 0; mode_b = 0; mode_c = 0;
    load_a = 0; load_b = 0; load_c = 0;
    d_a = 0; d_b = 0; d_c = 0;
    edge_step();
    edge_step();
    n_vec++;
    if ({q_a, qb_a, z1_a, z2_a, tick_a} !== {4'h0, 4'hF, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_a: got Q=%h Qb=%h Z1=%b Z2=%b tick=%b, want 0 F 0 1 0",
               q_a, qb_a, z1_a, z2_a, tick_a);
    end
    n_vec++;
    if ({q_b, qb_b, z1_b, z2_b, tick_b} !== {4'h0, 4'hF, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_b: got Q=%h Qb=%h Z1=%b Z2=%b tick=%b, want 0 F 0 1 0",
               q_b, qb_b, z1_b, z2_b, tick_b);
    end
    n_vec++;
    if ({q_c, qb_c, z1_c, z2_c, tick_c} !== {4'h0, 4'hF, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_c: got Q=%h Qb=%h Z1=%b Z2=%b tick=%b, want 0 F 0 1 0",
               q_c, qb_c, z1_c, z2_c, tick_c);
    end
    reset = 1'b1;
  endtask

  task automatic test_count_up;
    logic [3:0] e;
    logic       ez1;
    en_a = 1; mode_a = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      edge_step();
      e   = 4'(k % 16);
      ez1 = (k == 16);
      n_vec++;
      if ({q_a, qb_a, z1_a, z2_a, tick_a} !== {e, ~e, ez1, (e == 4'h0), 1'b1}) begin
        n_bad++;
        $display("FAIL count_up[%0d]: got Q=%h Qb=%h Z1=%b Z2=%b tick=%b, want %h %h %b %b 1",
                 k, q_a, qb_a, z1_a, z2_a, tick_a, e, ~e, ez1, (e == 4'h0));
      end
    end
    en_a = 0;
    edge_step();
    n_vec++;
    if ({q_a, z1_a, tick_a} !== {4'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL up_z1_drop: got Q=%h Z1=%b tick=%b, want 0 0 0", q_a, z1_a, tick_a);
    end
  endtask

  task automatic test_divider;
    logic [16:0] pat;
    logic        cur;
    pat   = 17'b11111111_000_111111;
    b_q   = 4'h0;
    b_div = 0;
    mode_b = 2'b01;
    en_b   = pat[0];
    n_vec++;
    if (tick_b !== 1'b0) begin
      n_bad++;
      $display("FAIL div_start_tick: got %b, want 0", tick_b);
    end
    for (int i = 0; i < 17; i++) begin
      cur = pat[i];
      edge_step();
      if (cur) begin
        if (b_div == 3) begin
          b_div = 0;
          b_q   = b_q + 4'd1;
        end else begin
          b_div = b_div + 1;
        end
      end
      en_b = (i < 16) ? pat[i+1] : 1'b0;
      n_vec++;
      if ({q_b, tick_b} !== {b_q, (en_b && b_div == 3)}) begin
        n_bad++;
        $display("FAIL divider[%0d]: got Q=%h tick=%b, want Q=%h tick=%b",
                 i, q_b, tick_b, b_q, (en_b && b_div == 3));
      end
    end
  endtask

  task automatic test_count_down;
    logic [3:0] e;
    logic       ez1;
    e = 4'h0;
    en_c = 1; mode_c = 2'b10;
    for (int k = 0; k < 11; k++) begin
      edge_step();
      if (e == 4'h0) begin
        e = 4'd9; ez1 = 1'b1;
      end else begin
        e = e - 4'd1; ez1 = 1'b0;
      end
      n_vec++;
      if ({q_c, qb_c, z1_c, z2_c} !== {e, ~e, ez1, (e == 4'h0)}) begin
        n_bad++;
        $display("FAIL count_down[%0d]: got Q=%h Qb=%h Z1=%b Z2=%b, want %h %h %b %b",
                 k, q_c, qb_c, z1_c, z2_c, e, ~e, ez1, (e == 4'h0));
      end
    end
    en_c = 0;
  endtask

  task automatic test_load;
    // Clamp, and load beating a wrapping up-step on the same edge.
    en_c = 1; mode_c = 2'b01; load_c = 1; d_c = 4'd12;
    edge_step();
    n_vec++;
    if ({q_c, z1_c} !== {4'd9, 1'b0}) begin
      n_bad++;
      $display("FAIL load_clamp: got Q=%h Z1=%b, want 9 0", q_c, z1_c);
    end
    d_c = 4'd3;
    edge_step();
    n_vec++;
    if ({q_c, z1_c} !== {4'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL load_over_wrap: got Q=%h Z1=%b, want 3 0", q_c, z1_c);
    end
    load_c = 0; en_c = 0;

    // Divider: load on a tick edge restarts the period.
    en_b = 1;
    edge_step();
    n_vec++;
    if ({q_b, tick_b} !== {4'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL load_pre_tick: got Q=%h tick=%b, want 3 1", q_b, tick_b);
    end
    load_b = 1; d_b = 4'd7;
    edge_step();
    load_b = 0;
    n_vec++;
    if ({q_b, tick_b} !== {4'd7, 1'b0}) begin
      n_bad++;
      $display("FAIL load_on_tick: got Q=%h tick=%b, want 7 0", q_b, tick_b);
    end
    for (int k = 1; k <= 4; k++) begin
      edge_step();
      n_vec++;
      if ({q_b, tick_b} !== {(k == 4) ? 4'd8 : 4'd7, (k == 3)}) begin
        n_bad++;
        $display("FAIL load_period[%0d]: got Q=%h tick=%b, want %h %b",
                 k, q_b, tick_b, (k == 4) ? 4'd8 : 4'd7, (k == 3));
      end
    end
    en_b = 0;
  endtask

  task automatic test_toggle;
    logic [3:0] ea [3];
    logic [3:0] ec [3];
    ea[0] = 4'd5; ea[1] = 4'd10; ea[2] = 4'd5;
    ec[0] = 4'd5; ec[1] = 4'd9;  ec[2] = 4'd6;
    load_a = 1; d_a = 4'd5; mode_a = 2'b11; en_a = 1;
    load_c = 1; d_c = 4'd5; mode_c = 2'b11; en_c = 1;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      load_a = 0; load_c = 0;
      n_vec++;
      if ({q_a, qb_a, z1_a} !== {ea[k], ~ea[k], 1'b0}) begin
        n_bad++;
        $display("FAIL toggle_a[%0d]: got Q=%h Qb=%h Z1=%b, want %h %h 0",
                 k, q_a, qb_a, z1_a, ea[k], ~ea[k]);
      end
      n_vec++;
      if ({q_c, qb_c, z1_c} !== {ec[k], ~ec[k], 1'b0}) begin
        n_bad++;
        $display("FAIL toggle_c[%0d]: got Q=%h Qb=%h Z1=%b, want %h %h 0",
                 k, q_c, qb_c, z1_c, ec[k], ~ec[k]);
      end
    end
    en_a = 0; en_c = 0;
  endtask

  task automatic test_reset_collision;
    load_b = 1; d_b = 4'd15;
    edge_step();
    load_b = 0; en_b = 1; mode_b = 2'b01;
    edge_step();
    edge_step();
    load_a = 1; d_a = 4'd15; en_a = 1; mode_a = 2'b01;
    edge_step();
    n_vec++;
    if ({q_a, tick_a, q_b, tick_b} !== {4'd15, 1'b1, 4'd15, 1'b1}) begin
      n_bad++;
      $display("FAIL collide_setup: got Qa=%h ta=%b Qb=%h tb=%b, want F 1 F 1",
               q_a, tick_a, q_b, tick_b);
    end
    reset = 0; load_a = 1; d_a = 4'd7; load_b = 1; d_b = 4'd7;
    edge_step();
    n_vec++;
    if ({q_a, qb_a, z1_a, z2_a} !== {4'h0, 4'hF, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL collide_a: got Q=%h Qb=%h Z1=%b Z2=%b, want 0 F 0 1",
               q_a, qb_a, z1_a, z2_a);
    end
    n_vec++;
    if ({q_b, qb_b, z1_b, z2_b, tick_b} !== {4'h0, 4'hF, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL collide_b: got Q=%h Qb=%h Z1=%b Z2=%b tick=%b, want 0 F 0 1 0",
               q_b, qb_b, z1_b, z2_b, tick_b);
    end
    reset = 1; load_a = 0; load_b = 0;
    edge_step();
    n_vec++;
    if ({q_a, q_b, tick_b} !== {4'd1, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL collide_release: got Qa=%h Qb=%h tb=%b, want 1 0 0",
               q_a, q_b, tick_b);
    end
    en_a = 0; en_b = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_divider();
    test_count_down();
    test_load();
    test_toggle();
    test_reset_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
